// File: rtl/fp32_mul_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fp32_mul_seq_ctrl
// Brief    : Sequential shift-add FP32 multiplier with valid/ready handshakes.
//            Define FP_MUL_RNE_EN for round-to-nearest-even (default: truncate).
// Revision : 1.0  initial release
// ============================================================================
module fp32_mul_seq_ctrl #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_overflow,
    output logic        out_underflow,
    output logic        out_invalid
);

    localparam int          MUL_CYCLES = 24 / BITS_PER_CYCLE;
    localparam logic [4:0]  c_LAST_CNT = 5'(MUL_CYCLES - 1);
    localparam logic [31:0] c_QNAN     = 32'h7FC0_0000;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_MUL  = 2'd1;
    localparam logic [1:0] c_NORM = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    generate
        if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 ||
              BITS_PER_CYCLE == 4 || BITS_PER_CYCLE == 8)) begin : g_bad_bpc
            $error("fp32_mul_seq_ctrl: BITS_PER_CYCLE must be 1, 2, 4 or 8");
        end
    endgenerate

    logic [1:0]        state_q,  state_d;
    logic [4:0]        cnt_q,    cnt_d;
    logic [47:0]       acc_q,    acc_d;
    logic [47:0]       mcand_q,  mcand_d;
    logic [23:0]       mplier_q, mplier_d;
    logic signed [9:0] exp_q,    exp_d;
    logic              sign_q,   sign_d;
    logic [31:0]       result_q, result_d;
    logic              ovf_q,    ovf_d;
    logic              unf_q,    unf_d;
    logic              inv_q,    inv_d;

    // Operand unpack; exponent 0 means zero (subnormals are flushed)
    logic [7:0]        w_a_exp, w_b_exp;
    logic [22:0]       w_a_man, w_b_man;
    logic              w_a_zero, w_a_inf, w_a_nan;
    logic              w_b_zero, w_b_inf, w_b_nan;
    logic              w_sign, w_special;
    logic signed [9:0] w_exp_sum;

    assign w_a_exp   = in_a[30:23];
    assign w_b_exp   = in_b[30:23];
    assign w_a_man   = in_a[22:0];
    assign w_b_man   = in_b[22:0];
    assign w_a_zero  = (w_a_exp == 8'd0);
    assign w_b_zero  = (w_b_exp == 8'd0);
    assign w_a_inf   = (w_a_exp == 8'hFF) && (w_a_man == 23'd0);
    assign w_b_inf   = (w_b_exp == 8'hFF) && (w_b_man == 23'd0);
    assign w_a_nan   = (w_a_exp == 8'hFF) && (w_a_man != 23'd0);
    assign w_b_nan   = (w_b_exp == 8'hFF) && (w_b_man != 23'd0);
    assign w_sign    = in_a[31] ^ in_b[31];
    assign w_special = w_a_zero | w_a_inf | w_a_nan | w_b_zero | w_b_inf | w_b_nan;
    assign w_exp_sum = $signed({2'b00, w_a_exp}) + $signed({2'b00, w_b_exp}) - 10'sd127;

    logic [31:0] w_spec_result;
    logic        w_spec_invalid;

    always_comb begin
        w_spec_result  = {w_sign, 31'd0};
        w_spec_invalid = 1'b0;
        if (w_a_nan || w_b_nan) begin
            w_spec_result = c_QNAN;
        end else if ((w_a_inf && w_b_zero) || (w_a_zero && w_b_inf)) begin
            w_spec_result  = c_QNAN;
            w_spec_invalid = 1'b1;
        end else if (w_a_inf || w_b_inf) begin
            w_spec_result = {w_sign, 8'hFF, 23'd0};
        end
    end

    logic [47:0] w_acc_sum;

    always_comb begin
        w_acc_sum = acc_q;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (mplier_q[i]) begin
                w_acc_sum = w_acc_sum + (mcand_q << i);
            end
        end
    end

    logic [22:0]       w_man;
    logic signed [9:0] w_exp_n;
    logic [31:0]       w_norm_result;
    logic              w_norm_ovf, w_norm_unf;
`ifdef FP_MUL_RNE_EN
    logic              w_guard, w_sticky;
    logic [23:0]       w_round;
`endif

    always_comb begin
        w_man   = acc_q[47] ? acc_q[46:24] : acc_q[45:23];
        w_exp_n = acc_q[47] ? exp_q + 10'sd1 : exp_q;
`ifdef FP_MUL_RNE_EN
        w_guard  = acc_q[47] ? acc_q[23] : acc_q[22];
        w_sticky = acc_q[47] ? (|acc_q[22:0]) : (|acc_q[21:0]);
        w_round  = {1'b0, w_man} + {23'd0, w_guard & (w_sticky | w_man[0])};
        w_man    = w_round[22:0];
        // Carry out of the fraction means the significand became 2.0
        if (w_round[23]) begin
            w_exp_n = w_exp_n + 10'sd1;
        end
`endif
        w_norm_ovf    = 1'b0;
        w_norm_unf    = 1'b0;
        w_norm_result = {sign_q, w_exp_n[7:0], w_man};
        if (w_exp_n >= 10'sd255) begin
            w_norm_result = {sign_q, 8'hFF, 23'd0};
            w_norm_ovf    = 1'b1;
        end else if (w_exp_n <= 10'sd0) begin
            w_norm_result = {sign_q, 31'd0};
            w_norm_unf    = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        exp_d    = exp_q;
        sign_d   = sign_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        inv_d    = inv_q;
        case (state_q)
            c_IDLE: begin
                if (in_valid) begin
                    sign_d   = w_sign;
                    exp_d    = w_exp_sum;
                    ovf_d    = 1'b0;
                    unf_d    = 1'b0;
                    inv_d    = 1'b0;
                    result_d = 32'd0;
                    if (w_special) begin
                        result_d = w_spec_result;
                        inv_d    = w_spec_invalid;
                        state_d  = c_DONE;
                    end else begin
                        acc_d    = 48'd0;
                        cnt_d    = 5'd0;
                        mcand_d  = {24'd0, 1'b1, w_a_man};
                        mplier_d = {1'b1, w_b_man};
                        state_d  = c_MUL;
                    end
                end
            end
            c_MUL: begin
                acc_d    = w_acc_sum;
                mcand_d  = mcand_q << BITS_PER_CYCLE;
                mplier_d = mplier_q >> BITS_PER_CYCLE;
                cnt_d    = cnt_q + 5'd1;
                if (cnt_q == c_LAST_CNT) begin
                    state_d = c_NORM;
                end
            end
            c_NORM: begin
                result_d = w_norm_result;
                ovf_d    = w_norm_ovf;
                unf_d    = w_norm_unf;
                state_d  = c_DONE;
            end
            default: begin
                if (out_ready) begin
                    state_d = c_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= c_IDLE;
            cnt_q    <= 5'd0;
            acc_q    <= 48'd0;
            mcand_q  <= 48'd0;
            mplier_q <= 24'd0;
            exp_q    <= 10'sd0;
            sign_q   <= 1'b0;
            result_q <= 32'd0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            inv_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            exp_q    <= exp_d;
            sign_q   <= sign_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            inv_q    <= inv_d;
        end
    end

    assign in_ready      = (state_q == c_IDLE);
    assign out_valid     = (state_q == c_DONE);
    assign out_result    = result_q;
    assign out_overflow  = ovf_q;
    assign out_underflow = unf_q;
    assign out_invalid   = inv_q;

endmodule
`default_nettype wire

// File: tb/tb_fp32_mul_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp32_mul_seq_ctrl
// Brief    : Directed self-checking bench for fp32_mul_seq_ctrl.
// Revision : 1.0  initial release
// ============================================================================
module tb_fp32_mul_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_overflow;
    logic        out_underflow;
    logic        out_invalid;

    int n_checks = 0;
    int n_pass   = 0;

    fp32_mul_seq_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_overflow (out_overflow),
        .out_underflow(out_underflow),
        .out_invalid  (out_invalid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one operation from IDLE (called at a negedge), wait for the result, retire it
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic [2:0] flags, output int lat);
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        res       = out_result;
        flags     = {out_overflow, out_underflow, out_invalid};
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [2:0]  flags;  // {overflow, underflow, invalid}
        int          lat;
    } vec_t;

    localparam logic [31:0] RND_EXP =
`ifdef FP_MUL_RNE_EN
        32'h3FC0_0002;
`else
        32'h3FC0_0001;
`endif

    vec_t vecs[11] = '{
        '{"1.5x2",      32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 3'b000, 26},
        '{"-2x3",       32'hC000_0000, 32'h4040_0000, 32'hC0C0_0000, 3'b000, 26},
        '{"infx0",      32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 3'b001, 1},
        '{"ovf",        32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000, 3'b100, 26},
        '{"round",      32'h3F80_0001, 32'h3FC0_0000, RND_EXP,       3'b000, 26},
        '{"1.5x1.5",    32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 3'b000, 26},
        '{"unf",        32'h0080_0000, 32'h3F00_0000, 32'h0000_0000, 3'b010, 26},
        '{"nan",        32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 3'b000, 1},
        '{"infxneg",    32'h7F80_0000, 32'hC000_0000, 32'hFF80_0000, 3'b000, 1},
        '{"zeroxneg",   32'h0000_0000, 32'hC040_0000, 32'h8000_0000, 3'b000, 1},
        '{"subnormal",  32'h0000_0001, 32'h4000_0000, 32'h0000_0000, 3'b000, 1}
    };

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] res;
        logic [2:0]  flags;
        logic [31:0] held;
        int          lat;
        int          bad;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_a      = 32'd0;
        in_b      = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_in_ready",  {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result",    out_result, 32'd0);
        check("rst_flags",     {29'd0, out_overflow, out_underflow, out_invalid}, 32'd0);

        foreach (vecs[i]) begin
            do_op(vecs[i].a, vecs[i].b, res, flags, lat);
            check({vecs[i].name, "_res"},   res, vecs[i].res);
            check({vecs[i].name, "_flags"}, {29'd0, flags}, {29'd0, vecs[i].flags});
            check({vecs[i].name, "_lat"},   32'(lat), 32'(vecs[i].lat));
        end

        // Backpressure: hold the result while a second request is presented
        in_a     = 32'h3FC0_0000;
        in_b     = 32'h4000_0000;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_a = 32'h4000_0000;
        in_b = 32'h4000_0000;
        lat  = 1;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("bp_lat", 32'(lat), 32'd26);
        held = out_result;
        check("bp_result", held, 32'h4040_0000);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_result !== held || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
        end
        check("bp_hold_bad_cycles", 32'(bad), 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_in_ready_after", {31'd0, in_ready}, 32'd1);
        check("bp_out_valid_after", {31'd0, out_valid}, 32'd0);
        repeat (3) @(negedge clk);
        check("bp_no_second_accept", {31'd0, in_ready}, 32'd1);

        // Reset during MUL aborts the operation
        in_a     = 32'h3FC0_0000;
        in_b     = 32'h4000_0000;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_in_ready",  {31'd0, in_ready}, 32'd1);
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_result",    out_result, 32'd0);
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid !== 1'b0) bad++;
        end
        check("abort_no_result", 32'(bad), 32'd0);
        do_op(32'h3FC0_0000, 32'h4000_0000, res, flags, lat);
        check("post_abort_res", res, 32'h4040_0000);
        check("post_abort_lat", 32'(lat), 32'd26);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
